ina226_power_supervisor: RTL and testbench
==========================================

Name: ina226_power_supervisor

Overview:
Downstream consumer of the INA226 controller. Paces polls with a programmable interval timer and captures bus_voltage/current_scaled on each poll_done. Computes instantaneous power, exponentially averaged voltage/current, and debounced under-voltage, over-voltage, over-current and poll-timeout faults. Outputs feed board-level power sequencing and telemetry registers.

Parameters:
POLL_INTERVAL, 1000000, clk cycles between successive poll_en pulses (start-to-start); must be >= 4
TIMEOUT, 65535, clk cycles allowed from poll_en pulse to poll_done before a timeout fault
AVG_SHIFT, 3, EMA weight 2^-AVG_SHIFT; 0 disables averaging (avg = raw); legal range 0..8
VBUS_MIN, 16'd3840, under-voltage threshold, unsigned raw code (1.25 mV/LSB; 4.8 V)
VBUS_MAX, 16'd4160, over-voltage threshold, unsigned raw code (5.2 V)
IMAX, 16'sd20000, over-current threshold, signed raw code, compared against |current|
FAULT_COUNT, 3, consecutive violating samples required to trip a fault (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  polling enable
ina_booting  in  1  INA226 block still configuring; no polls issued while high
poll_en  out  1  single-cycle poll request to INA226 block
poll_done  in  1  single-cycle pulse; bus_voltage/current_scaled valid that cycle
bus_voltage  in  16  unsigned, 1.25 mV/LSB
current_scaled  in  16  signed two's complement current code
fault_clear  in  1  clears all sticky fault flags
sample_valid  out  1  pulse: all data outputs updated this cycle
vbus_raw  out  16  last captured bus voltage
current_raw  out  16  last captured current (signed)
power  out  32  signed, vbus_raw * current_raw
vbus_avg  out  16  EMA of bus voltage (unsigned)
current_avg  out  16  EMA of current (signed)
fault_uv / fault_ov / fault_oc / fault_timeout  out  1 each  sticky fault flags
fault_any  out  1  OR of the four fault flags (combinational from flags)

Behaviour:
- Reset: every output 0, state IDLE, timers/counters 0, averager "first sample" flag set.
- FSM: IDLE -> (enable & !ina_booting) pulse poll_en, load interval and timeout counters -> WAIT_DONE.
- WAIT_DONE: poll_done -> capture inputs -> MULTIPLY. Timeout counter expiry -> set fault_timeout -> WAIT_TIMER.
- MULTIPLY: register 16u x 16s product into power (exact; fits 32-bit signed) -> UPDATE.
- UPDATE: update averages and fault counters, assert sample_valid for exactly one cycle -> WAIT_TIMER.
- WAIT_TIMER: on interval expiry pulse poll_en if enable & !ina_booting, else -> IDLE.
- Latency: poll_done at cycle N -> sample_valid at N+2; vbus_raw/current_raw visible from N+1.
- Interval counter runs from poll_en, so period is independent of poll latency. If the poll outlasts the interval, the next poll_en is issued the cycle after UPDATE.
- poll_done outside WAIT_DONE is ignored, including a late pulse after a timeout or one that follows reset.
- enable deasserted mid-poll: outstanding poll completes normally, then the FSM goes to IDLE.
- EMA: avg <= avg + ((x - avg) >>> AVG_SHIFT), computed at 18-bit signed width then truncated. The first sample after reset loads avg = x directly.
- Fault counters, one per UV/OV/OC, saturating 8-bit:
  - violation is vbus < VBUS_MIN, vbus > VBUS_MAX, or |current| > IMAX, with |-32768| treated as 32768;
  - violating sample increments the counter; non-violating sample zeroes it;
  - flag sets when the counter reaches FAULT_COUNT.
- Flags are sticky. fault_clear zeroes flags and counters. If a set and fault_clear occur in the same cycle, the set wins.
- Timeout does not alter averages or the raw/power outputs.

Decomposition:
- Package ina226_supervisor_pkg: state enum (IDLE, WAIT_DONE, MULTIPLY, UPDATE, WAIT_TIMER), fault index constants (FAULT_UV=0, FAULT_OV=1, FAULT_OC=2, FAULT_TIMEOUT=3).
- Sub-module ema_filter (params WIDTH, SHIFT, SIGNED; ports clk, rst, in_valid, din, dout), instantiated once for voltage and once for current.

Test Plan:
Bench parameters for all scenarios: POLL_INTERVAL=100, TIMEOUT=50, AVG_SHIFT=2, FAULT_COUNT=3. Bench models the INA226 block, answering poll_en after 20 cycles.
- Boot gating: ina_booting high for 500 cycles with enable=1 -> no poll_en. First poll_en 1 cycle after ina_booting falls, then every 100 cycles.
- Arithmetic: vbus=4000, current=-1234 -> sample_valid 2 cycles after poll_done, power=-4936000. First sample gives vbus_avg=4000. Next sample vbus=4400 -> vbus_avg=4100.
- Debounce: vbus=3800 for 2 polls then 4000 -> fault_uv stays 0. vbus=3800 for 3 polls -> fault_uv=1 on the 3rd sample_valid and stays set after vbus recovers. fault_clear -> 0.
- Over-current sign: current=-20001 for 3 polls -> fault_oc=1. current=20000 for 3 polls -> fault_oc=0.
- Timeout: no poll_done -> fault_timeout=1 exactly 50 cycles after poll_en. Late poll_done ignored (sample_valid stays 0). Next poll_en 100 cycles after the previous one.
- Reset mid-poll: assert rst in WAIT_DONE -> all outputs 0 immediately. A poll_done during/after reset while IDLE is ignored; polling resumes after rst release.

Source files
------------

// File: rtl/ina226_supervisor_pkg.sv
// Shared FSM state encoding, fault indices and helpers for the INA226 power supervisor.
package ina226_supervisor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    MULTIPLY,
    UPDATE,
    WAIT_TIMER
  } state_t;

  localparam int FAULT_UV          = 0;
  localparam int FAULT_OV          = 1;
  localparam int FAULT_OC          = 2;
  localparam int FAULT_TIMEOUT     = 3;
  localparam int NUM_SAMPLE_FAULTS = 3;

  // Debounce counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/ema_filter.sv
// Exponential moving average: avg += (x - avg) >>> SHIFT, with the first sample loaded directly.
module ema_filter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SHIFT  = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Two guard bits keep the difference of two full-range values exact.
  localparam int unsigned EW = WIDTH + 2;

  logic                 first_reg;
  logic signed [EW-1:0] din_ext;
  logic signed [EW-1:0] avg_ext;
  logic signed [EW-1:0] delta;

  assign din_ext = SIGNED ? {{2{din[WIDTH-1]}}, din} : {2'b00, din};
  assign avg_ext = SIGNED ? {{2{dout[WIDTH-1]}}, dout} : {2'b00, dout};
  assign delta   = din_ext - avg_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_reg <= 1'b1;
      dout      <= '0;
    end else if (in_valid) begin
      first_reg <= 1'b0;
      if (first_reg) begin
        dout <= din;
      end else begin
        dout <= WIDTH'(avg_ext + (delta >>> SHIFT));
      end
    end
  end

endmodule

// File: rtl/ina226_power_supervisor.sv
// Paces INA226 polls, captures each reading, derives power and averages, and raises
// debounced UV/OV/OC plus poll-timeout faults.
module ina226_power_supervisor
  import ina226_supervisor_pkg::*;
#(
  parameter int unsigned        POLL_INTERVAL = 1000000,
  parameter int unsigned        TIMEOUT       = 65535,
  parameter int unsigned        AVG_SHIFT     = 3,
  parameter logic        [15:0] VBUS_MIN      = 16'd3840,
  parameter logic        [15:0] VBUS_MAX      = 16'd4160,
  parameter logic signed [15:0] IMAX          = 16'sd20000,
  parameter int unsigned        FAULT_COUNT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               ina_booting,
  output logic               poll_en,
  input  logic               poll_done,
  input  logic        [15:0] bus_voltage,
  input  logic signed [15:0] current_scaled,
  input  logic               fault_clear,
  output logic               sample_valid,
  output logic        [15:0] vbus_raw,
  output logic signed [15:0] current_raw,
  output logic signed [31:0] power,
  output logic        [15:0] vbus_avg,
  output logic signed [15:0] current_avg,
  output logic               fault_uv,
  output logic               fault_ov,
  output logic               fault_oc,
  output logic               fault_timeout,
  output logic               fault_any
);

  localparam logic [31:0] INTERVAL_LOAD = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] TIMEOUT_LOAD  = 32'(TIMEOUT - 1);

  state_t             state_reg;
  logic        [31:0] interval_cnt_reg;
  logic        [31:0] timeout_cnt_reg;
  logic               can_poll;
  logic               interval_done;
  logic               start_poll;
  logic               sample_update;
  logic signed [31:0] vbus_ext;
  logic signed [31:0] cur_ext;

  assign can_poll      = enable && !ina_booting;
  assign interval_done = (interval_cnt_reg == '0);
  assign sample_update = (state_reg == MULTIPLY);
  // UPDATE may issue directly so an overrunning poll restarts one cycle after it completes.
  assign start_poll    = can_poll && ((state_reg == IDLE) ||
                         (((state_reg == UPDATE) || (state_reg == WAIT_TIMER)) && interval_done));

  assign vbus_ext = {16'b0, vbus_raw};
  assign cur_ext  = {{16{current_raw[15]}}, current_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      interval_cnt_reg <= '0;
      timeout_cnt_reg  <= '0;
      poll_en          <= 1'b0;
      sample_valid     <= 1'b0;
      vbus_raw         <= '0;
      current_raw      <= '0;
      power            <= '0;
      fault_timeout    <= 1'b0;
    end else begin
      poll_en      <= 1'b0;
      sample_valid <= 1'b0;
      if (!interval_done)          interval_cnt_reg <= interval_cnt_reg - 32'd1;
      if (timeout_cnt_reg != '0)   timeout_cnt_reg  <= timeout_cnt_reg - 32'd1;
      if (fault_clear)             fault_timeout    <= 1'b0;
      if (start_poll) begin
        poll_en          <= 1'b1;
        interval_cnt_reg <= INTERVAL_LOAD;
        timeout_cnt_reg  <= TIMEOUT_LOAD;
      end
      unique case (state_reg)
        IDLE: begin
          if (start_poll) state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (poll_done) begin
            vbus_raw    <= bus_voltage;
            current_raw <= current_scaled;
            state_reg   <= MULTIPLY;
          end else if (timeout_cnt_reg == '0) begin
            fault_timeout <= 1'b1;
            state_reg     <= WAIT_TIMER;
          end
        end
        MULTIPLY: begin
          power        <= vbus_ext * cur_ext;
          sample_valid <= 1'b1;
          state_reg    <= UPDATE;
        end
        UPDATE, WAIT_TIMER: begin
          if (!interval_done) state_reg <= WAIT_TIMER;
          else if (start_poll) state_reg <= WAIT_DONE;
          else                 state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  ema_filter #(.WIDTH(16), .SHIFT(AVG_SHIFT), .SIGNED(1'b0)) u_vbus_ema (
    .clk      (clk),
    .rst      (rst),
    .in_valid (sample_update),
    .din      (vbus_raw),
    .dout     (vbus_avg)
  );

  ema_filter #(.WIDTH(16), .SHIFT(AVG_SHIFT), .SIGNED(1'b1)) u_current_ema (
    .clk      (clk),
    .rst      (rst),
    .in_valid (sample_update),
    .din      (current_raw),
    .dout     (current_avg)
  );

  logic [16:0]                  cur_mag;
  logic [NUM_SAMPLE_FAULTS-1:0] viol;
  logic [NUM_SAMPLE_FAULTS-1:0] trip;
  logic [NUM_SAMPLE_FAULTS-1:0] flag_reg;
  logic [7:0]                   cnt_reg [NUM_SAMPLE_FAULTS];
  logic [7:0]                   cnt_inc [NUM_SAMPLE_FAULTS];

  // 17-bit magnitude so -32768 compares as +32768.
  assign cur_mag = current_raw[15] ? (17'd0 - {1'b1, current_raw}) : {1'b0, current_raw};

  assign viol[FAULT_UV] = (vbus_raw < VBUS_MIN);
  assign viol[FAULT_OV] = (vbus_raw > VBUS_MAX);
  assign viol[FAULT_OC] = (cur_mag > {1'b0, IMAX});

  generate
    for (genvar gi = 0; gi < NUM_SAMPLE_FAULTS; gi++) begin : g_fault
      assign cnt_inc[gi] = sat_inc(cnt_reg[gi]);
      assign trip[gi]    = viol[gi] && (cnt_inc[gi] >= 8'(FAULT_COUNT));
    end
  endgenerate

  // A trip on the same cycle as fault_clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_reg <= '0;
      for (int i = 0; i < NUM_SAMPLE_FAULTS; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SAMPLE_FAULTS; i++) begin
        if (sample_update)    cnt_reg[i] <= viol[i] ? cnt_inc[i] : 8'd0;
        else if (fault_clear) cnt_reg[i] <= 8'd0;
        if (sample_update && trip[i]) flag_reg[i] <= 1'b1;
        else if (fault_clear)         flag_reg[i] <= 1'b0;
      end
    end
  end

  logic [3:0] fault_vec;

  assign fault_uv  = flag_reg[FAULT_UV];
  assign fault_ov  = flag_reg[FAULT_OV];
  assign fault_oc  = flag_reg[FAULT_OC];
  assign fault_vec[FAULT_UV]      = fault_uv;
  assign fault_vec[FAULT_OV]      = fault_ov;
  assign fault_vec[FAULT_OC]      = fault_oc;
  assign fault_vec[FAULT_TIMEOUT] = fault_timeout;
  assign fault_any = |fault_vec;

endmodule

// File: tb/tb_ina226_power_supervisor.sv
// Randomized bench for ina226_power_supervisor with an arithmetic reference model
// and a simple INA226 responder that answers poll_en after a fixed latency.
module tb_ina226_power_supervisor;

  localparam int POLL_INTERVAL = 100;
  localparam int TIMEOUT       = 50;
  localparam int AVG_SHIFT     = 2;
  localparam int FAULT_COUNT   = 3;
  localparam int LAT           = 20;
  localparam int VMIN          = 3840;
  localparam int VMAX          = 4160;
  localparam int IMAX          = 20000;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               ina_booting;
  logic               poll_en;
  logic               poll_done;
  logic        [15:0] bus_voltage;
  logic signed [15:0] current_scaled;
  logic               fault_clear;
  logic               sample_valid;
  logic        [15:0] vbus_raw;
  logic signed [15:0] current_raw;
  logic signed [31:0] power;
  logic        [15:0] vbus_avg;
  logic signed [15:0] current_avg;
  logic               fault_uv, fault_ov, fault_oc, fault_timeout, fault_any;

  ina226_power_supervisor #(
    .POLL_INTERVAL (POLL_INTERVAL),
    .TIMEOUT       (TIMEOUT),
    .AVG_SHIFT     (AVG_SHIFT),
    .VBUS_MIN      (16'd3840),
    .VBUS_MAX      (16'd4160),
    .IMAX          (16'sd20000),
    .FAULT_COUNT   (FAULT_COUNT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .ina_booting    (ina_booting),
    .poll_en        (poll_en),
    .poll_done      (poll_done),
    .bus_voltage    (bus_voltage),
    .current_scaled (current_scaled),
    .fault_clear    (fault_clear),
    .sample_valid   (sample_valid),
    .vbus_raw       (vbus_raw),
    .current_raw    (current_raw),
    .power          (power),
    .vbus_avg       (vbus_avg),
    .current_avg    (current_avg),
    .fault_uv       (fault_uv),
    .fault_ov       (fault_ov),
    .fault_oc       (fault_oc),
    .fault_timeout  (fault_timeout),
    .fault_any      (fault_any)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_poll = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic over the sample history.
  int m_vraw, m_iraw, m_vavg, m_iavg;
  bit m_first;
  int m_cnt[3];
  bit m_flag[4];

  function automatic int ema_step(input int avg, input int x);
    int d;
    int w;
    d = x - avg;
    w = 1 << AVG_SHIFT;
    if (d >= 0) return avg + d / w;
    return avg - ((-d + w - 1) / w);
  endfunction

  task automatic model_reset();
    m_vraw = 0; m_iraw = 0; m_vavg = 0; m_iavg = 0; m_first = 1'b1;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    for (int k = 0; k < 4; k++) m_flag[k] = 1'b0;
  endtask

  task automatic model_sample(input int v, input int i);
    bit viol[3];
    m_vraw = v;
    m_iraw = i;
    if (m_first) begin
      m_vavg = v; m_iavg = i; m_first = 1'b0;
    end else begin
      m_vavg = ema_step(m_vavg, v);
      m_iavg = ema_step(m_iavg, i);
    end
    viol[0] = (v < VMIN);
    viol[1] = (v > VMAX);
    viol[2] = (((i < 0) ? -i : i) > IMAX);
    for (int k = 0; k < 3; k++) begin
      if (viol[k]) m_cnt[k] = (m_cnt[k] < 255) ? m_cnt[k] + 1 : 255;
      else         m_cnt[k] = 0;
      if (m_cnt[k] >= FAULT_COUNT) m_flag[k] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_eq("vbus_raw", vbus_raw, m_vraw);
    check_eq("current_raw", current_raw, m_iraw);
    check_eq("power", power, longint'(m_vraw) * longint'(m_iraw));
    check_eq("vbus_avg", vbus_avg, m_vavg);
    check_eq("current_avg", current_avg, m_iavg);
    check_eq("fault_uv", fault_uv, m_flag[0]);
    check_eq("fault_ov", fault_ov, m_flag[1]);
    check_eq("fault_oc", fault_oc, m_flag[2]);
    check_eq("fault_timeout", fault_timeout, m_flag[3]);
    check_eq("fault_any", fault_any, m_flag[0] | m_flag[1] | m_flag[2] | m_flag[3]);
  endtask

  task automatic wait_poll(output int p);
    p = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (poll_en) begin
        p = cyc;
        break;
      end
    end
    if (p < 0) check_eq("poll_en_seen", 0, 1);
  endtask

  task automatic do_poll(input int v, input int i, input bit chk_period);
    int p;
    wait_poll(p);
    if (p < 0) return;
    if (chk_period) check_eq("poll_period", p - last_poll, POLL_INTERVAL);
    last_poll = p;
    @(negedge clk);
    check_eq("poll_en_pulse", poll_en, 0);
    repeat (LAT - 1) @(negedge clk);
    poll_done = 1'b1; bus_voltage = 16'(v); current_scaled = 16'(i);
    @(negedge clk);
    poll_done = 1'b0;
    check_eq("raw_next_cycle", vbus_raw, v);
    check_eq("sv_early", sample_valid, 0);
    @(negedge clk);
    model_sample(v, i);
    check_eq("sample_valid", sample_valid, 1);
    check_outputs();
    $display("poll @%0d v=%0d i=%0d power=%0d vavg=%0d iavg=%0d flags(to,oc,ov,uv)=%b%b%b%b",
             p, v, i, power, vbus_avg, current_avg, fault_timeout, fault_oc, fault_ov, fault_uv);
    @(negedge clk);
    check_eq("sv_one_cycle", sample_valid, 0);
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    for (int k = 0; k < 4; k++) m_flag[k] = 1'b0;
    check_eq("clear_flags", {fault_timeout, fault_oc, fault_ov, fault_uv}, 0);
    check_eq("clear_any", fault_any, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, b, e, seen, v, i, vcat, icat, run;
    rst = 1'b1; enable = 1'b0; ina_booting = 1'b1; poll_done = 1'b0;
    bus_voltage = '0; current_scaled = '0; fault_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("reset_poll_en", poll_en, 0);
    check_eq("reset_sample_valid", sample_valid, 0);
    rst = 1'b0;

    // Boot gating
    enable = 1'b1;
    seen = 0;
    repeat (500) begin
      @(negedge clk);
      if (poll_en) seen++;
    end
    check_eq("boot_no_poll", seen, 0);
    ina_booting = 1'b0;
    b = cyc;
    do_poll(4000, -1234, 1'b0);
    check_eq("boot_release_latency", last_poll - b, 1);
    check_eq("power_directed", power, -4936000);
    check_eq("vbus_avg_first", vbus_avg, 4000);
    do_poll(4400, -1234, 1'b1);
    check_eq("vbus_avg_ema", vbus_avg, 4100);

    // Under-voltage debounce
    do_poll(3800, 0, 1'b1);
    do_poll(3800, 0, 1'b1);
    do_poll(4000, 0, 1'b1);
    check_eq("uv_two_no_trip", fault_uv, 0);
    do_poll(3800, 0, 1'b1);
    do_poll(3800, 0, 1'b1);
    do_poll(3800, 0, 1'b1);
    check_eq("uv_trip", fault_uv, 1);
    do_poll(4000, 0, 1'b1);
    check_eq("uv_sticky", fault_uv, 1);
    pulse_clear();

    // Over-current sign handling
    do_poll(4000, -20001, 1'b1);
    do_poll(4000, -20001, 1'b1);
    do_poll(4000, -20001, 1'b1);
    check_eq("oc_trip_neg", fault_oc, 1);
    pulse_clear();
    do_poll(4000, 20000, 1'b1);
    do_poll(4000, 20000, 1'b1);
    do_poll(4000, 20000, 1'b1);
    check_eq("oc_at_limit", fault_oc, 0);

    // Poll timeout and late response
    wait_poll(p);
    if (p >= 0) begin
      check_eq("poll_period", p - last_poll, POLL_INTERVAL);
      last_poll = p;
      repeat (TIMEOUT - 1) @(negedge clk);
      check_eq("timeout_early", fault_timeout, 0);
      @(negedge clk);
      m_flag[3] = 1'b1;
      check_eq("timeout_set", fault_timeout, 1);
      check_eq("timeout_any", fault_any, 1);
      repeat (5) @(negedge clk);
      poll_done = 1'b1; bus_voltage = 16'd1234; current_scaled = 16'sd555;
      @(negedge clk);
      poll_done = 1'b0;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (sample_valid) seen++;
      end
      check_eq("late_done_ignored", seen, 0);
      check_outputs();
    end
    do_poll(4000, 100, 1'b1);
    pulse_clear();

    // Randomized traffic in short runs of one category
    run = 0; vcat = 0; icat = 0;
    for (int n = 0; n < 40; n++) begin
      if (run == 0) begin
        vcat = int'($urandom_range(3, 0));
        icat = int'($urandom_range(4, 0));
        run  = int'($urandom_range(4, 1));
      end
      run--;
      case (vcat)
        0:       v = int'($urandom_range(3839, 3600));
        1:       v = int'($urandom_range(4160, 3840));
        2:       v = int'($urandom_range(4400, 4161));
        default: v = int'($urandom_range(65535, 0));
      endcase
      case (icat)
        0:       i = int'($urandom_range(20000, 19990));
        1:       i = int'($urandom_range(22000, 20001));
        2:       i = -32768;
        3:       i = int'($urandom_range(65535, 0)) - 32768;
        default: i = int'($urandom_range(2000, 0)) - 1000;
      endcase
      if ($urandom_range(1, 0) == 1) i = -i;
      if (i > 32767) i = 32767;
      do_poll(v, i, 1'b1);
      if ($urandom_range(4, 0) == 0) pulse_clear();
    end

    // Reset in the middle of a poll
    wait_poll(p);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    poll_done = 1'b1; bus_voltage = 16'd4000; current_scaled = 16'sd321;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_poll_en", poll_en, 0);
    check_eq("rst_sample_valid", sample_valid, 0);
    @(negedge clk);
    poll_done = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    poll_done = 1'b1;
    @(negedge clk);
    poll_done = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid || poll_en) seen++;
    end
    check_eq("idle_done_ignored", seen, 0);
    check_eq("idle_raw_kept", vbus_raw, 0);
    enable = 1'b1;
    e = cyc;
    do_poll(3950, -777, 1'b0);
    check_eq("resume_latency", last_poll - e, 1);
    do_poll(4050, 800, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
